// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the column mixer.
package aes_pkg;

  // One AES column: element [3] is row 0, element [0] is row 3, so the
  // packed value reads row0..row3 from MSB to LSB.
  typedef logic [3:0][7:0] column_t;

  // Full AES state: element [3] is column 0 (bits 127:96), element [0] is column 3.
  typedef column_t [3:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mixcol_state_e;

  // First row of each circulant matrix; row r is this row rotated right by r.
  localparam logic [7:0] ENC_ROW [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] DEC_ROW [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  // Multiply by 02 modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the constants used by MixColumns / InvMixColumns.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   return b;
      8'h02:   return x2;
      8'h03:   return x2 ^ b;
      8'h09:   return x8 ^ b;
      8'h0b:   return x8 ^ x2 ^ b;
      8'h0d:   return x8 ^ x4 ^ b;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_mix_one_column.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
module aes_mix_one_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        dec,
  output logic [31:0] col_out
);

  column_t a;
  column_t y;

  assign a       = col_in;
  assign col_out = y;

  // Row r output is XOR over k of M[r][k] * a_k, with M circulant.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        y[2'(3 - r)] = y[2'(3 - r)] ^
          gf_mul_const(a[2'(3 - k)], dec ? DEC_ROW[2'(k - r)] : ENC_ROW[2'(k - r)]);
      end
    end
  end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N_STEPS = 4 / COLS_PER_CYCLE;
  localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mixcol_state_e     state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              mode_q, mode_d;
  state_t            work_q, work_d;

  logic [1:0]  col_sel [COLS_PER_CYCLE];
  logic [31:0] mix_in  [COLS_PER_CYCLE];
  logic [31:0] mix_out [COLS_PER_CYCLE];

  // Pick the columns handled in the current step out of the working register.
  always_comb begin
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      col_sel[i] = 2'(int'(step_q) * COLS_PER_CYCLE + i);
      mix_in[i]  = work_q[2'd3 - col_sel[i]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    aes_mix_one_column u_mix (
      .col_in  (mix_in[g]),
      .dec     (mode_q),
      .col_out (mix_out[g])
    );
  end

  // Next-state, in-place column update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    mode_d    = mode_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_d[2'd3 - col_sel[i]] = mix_out[i];
        end
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Acceptance (from IDLE, or back-to-back out of DONE) overrides the above.
    if (in_valid && in_ready) begin
      work_d  = in_state;
      mode_d  = in_dec;
      step_d  = '0;
      state_d = RUN;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      mode_q  <= 1'b0;
      // NOTE: the working register is reset because it drives out_state, which must read zero after reset.
      work_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign out_state = work_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench: three engines (1, 2 and 4 columns per cycle) against a
// matrix-level GF(2^8) reference model.
module tb_aes_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n;

  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic         idec [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];
  logic         bsy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (ist[g]),
      .in_dec    (idec[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (ost[g]),
      .busy      (bsy[g])
    );
  end

  // Generic GF(2^8) multiply, shift-and-add modulo 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference: out[c][r] = XOR_k M[r][k] * in[c][k], M[r][k] = row0[(k-r) mod 4].
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic dec);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [1:0]   j;
    logic [127:0] o;
    if (dec) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          j   = 2'(k - r);
          acc = acc ^ gf_mul(row0[j], s[127 - 8 * (4 * c + k) -: 8]);
        end
        o[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 16) begin
      @(negedge clk);
      idec[k] = ~idec[k];
      ist[k]  = rnd128();
      lat++;
    end
  endtask

  // Accept one block on engine k from idle, check latency and result, drain it.
  task automatic run_block(input int k, input logic [127:0] s, input logic dec,
                           input logic [127:0] exp, input string tag, output logic [127:0] got);
    int lat;
    @(negedge clk);
    check($sformatf("%s in_ready k%0d", tag, k), 128'(ir[k]), 128'(1));
    iv[k] = 1'b1; ist[k] = s; idec[k] = dec;
    @(negedge clk);
    iv[k] = 1'b0;
    wait_out(k, lat);
    check($sformatf("%s latency k%0d", tag, k), 128'(lat), 128'(4 >> k));
    check($sformatf("%s data k%0d", tag, k), ost[k], exp);
    got = ost[k];
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    check($sformatf("%s drained k%0d", tag, k), 128'(ov[k]), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got, got2, orig, a_blk, b_blk, held;
    int lat;
    const logic [127:0] ENC_IN  = {4{32'hdb135345}};
    const logic [127:0] ENC_OUT = {4{32'h8e4da1bc}};
    const logic [127:0] MIX_IN  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
    const logic [127:0] MIX_OUT = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ist[k] = '0; idec[k] = 1'b0; ordy[k] = 1'b0;
    end
    rst_n = 1'b0;
    #23;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out_state k%0d", k), ost[k], '0);
      check($sformatf("reset flags k%0d", k), {125'd0, ir[k], ov[k], bsy[k]}, 128'b100);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed known-answer vectors.
    run_block(0, ENC_IN, 1'b0, ENC_OUT, "enc_db13", got);
    for (int k = 0; k < 3; k++) run_block(k, MIX_IN, 1'b0, MIX_OUT, "enc_mixed", got);
    run_block(0, ENC_OUT, 1'b1, ENC_IN, "dec_8e4d", got);

    // Random states against the model, both modes, every engine.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 4; n++) begin
        orig = rnd128();
        run_block(k, orig, n[0], ref_mix(orig, n[0]), "random", got);
      end
    end

    // Round trip: encrypt then decrypt returns the original state.
    orig = rnd128();
    run_block(0, orig, 1'b0, ref_mix(orig, 1'b0), "rt_enc", got);
    run_block(0, got, 1'b1, orig, "rt_dec", got2);

    // Backpressure: stall 5 cycles in DONE, then release with a new block.
    a_blk = rnd128();
    b_blk = rnd128();
    @(negedge clk);
    iv[0] = 1'b1; ist[0] = a_blk; idec[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    wait_out(0, lat);
    check("bp latency", 128'(lat), 128'(4));
    held = ost[0];
    check("bp data", held, ref_mix(a_blk, 1'b0));
    repeat (5) begin
      @(negedge clk);
      check("bp stable", ost[0], held);
      check("bp flags", {126'd0, ov[0], ir[0]}, 128'b10);
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; ist[0] = b_blk; idec[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0; iv[0] = 1'b0;
    check("bp accepted", {126'd0, ov[0], bsy[0]}, 128'b01);
    wait_out(0, lat);
    check("bp2 latency", 128'(lat), 128'(4));
    check("bp2 data", ost[0], ref_mix(b_blk, 1'b1));
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    // Mode per block: enc then dec back-to-back, in_dec toggling while busy.
    a_blk = rnd128();
    b_blk = rnd128();
    @(negedge clk);
    iv[0] = 1'b1; ist[0] = a_blk; idec[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    wait_out(0, lat);
    check("b2b enc data", ost[0], ref_mix(a_blk, 1'b0));
    iv[0] = 1'b1; ist[0] = b_blk; idec[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    check("b2b accept", 128'(ov[0]), 128'(0));
    wait_out(0, lat);
    check("b2b dec latency", 128'(lat), 128'(4));
    check("b2b dec data", ost[0], ref_mix(b_blk, 1'b1));
    @(negedge clk);
    ordy[0] = 1'b0;

    // Reset in the middle of a block (step 2 of 4).
    @(negedge clk);
    iv[0] = 1'b1; ist[0] = rnd128(); idec[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid out_state", ost[0], '0);
    check("rst mid flags", {125'd0, ir[0], ov[0], bsy[0]}, 128'b100);
    @(negedge clk);
    rst_n = 1'b1;
    orig = rnd128();
    run_block(0, orig, 1'b0, ref_mix(orig, 1'b0), "post_rst", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_seq.md
# aes_mix_columns_seq

Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath. It accepts one 128-bit state per valid/ready handshake and processes COLS_PER_CYCLE columns per clock, so area can be traded for latency. The mode (encrypt/decrypt) is selected per block. It sits between ShiftRows and AddRoundKey in the iterative round datapath and replaces the purely combinational column mixer when round logic is time-multiplexed.

## Interface
- COLS_PER_CYCLE, default 1: columns mixed per compute cycle. Legal values are 1, 2, 4; any other value is an elaboration error.
- N_STEPS, derived as 4/COLS_PER_CYCLE: number of compute cycles per block.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state/in_dec are valid.
- in_ready  output  1  block can accept a new state this cycle.
- in_state  input  128  column-major state. in_state[127:120] is A0 (row0, col0), and [119:112] is A1 (row1, col0). Column c occupies in_state[127-32c -: 32].
- in_dec  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  mixed state, same byte layout as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0. Step counter runs 0..N_STEPS-1.
  - DONE: out_valid=1. in_ready=out_ready.
- Accept happens when in_valid & in_ready. On accept:
  - in_state is loaded into the working register.
  - in_dec is latched into mode_q.
  - step resets to 0 and the FSM goes to RUN.
- RUN, each cycle:
  - Columns step*COLS_PER_CYCLE .. step*COLS_PER_CYCLE+COLS_PER_CYCLE-1 are replaced in place by their mixed value.
  - When step==N_STEPS-1, the FSM goes to DONE; otherwise step increments.
- Column arithmetic is over GF(2^8) with polynomial 0x11B.
  - Encrypt uses the circulant matrix rows {02 03 01 01}.
  - Decrypt uses {0E 0B 0D 09}.
  - Output row r of a column is the XOR of M[r][k]·a_k for k=0..3.
- DONE with out_ready=1:
  - If in_valid=1, the next block is accepted in the same cycle (back-to-back) and the FSM goes to RUN.
  - Otherwise the FSM goes to IDLE.
- DONE with out_ready=0: out_state and out_valid are held stable (no change while stalled).
- in_valid while not in_ready is ignored; input contents are don't-care.
- in_dec is ignored except at acceptance. Mode cannot change mid-block.

## Timing
- Reset (async assert, sync-released by system): FSM=IDLE, step=0, mode_q=0, out_state=0, out_valid=0, busy=0, in_ready=1.
- Latency: out_valid rises N_STEPS cycles after the accept edge (4 / 2 / 1 cycles for COLS_PER_CYCLE = 1 / 2 / 4).
- Throughput with out_ready tied high: one block per N_STEPS+1 cycles (accept edge coincides with previous completion edge).
- out_state is driven directly from the working register; no combinational path from in_state to out_state.
- rst_n asserted in RUN or DONE aborts the block immediately. No partial output is ever flagged valid.
- out_valid may only fall on an edge where out_ready=1 (or on reset).

## Structure
- Shared package aes_pkg:
  - function xtime (multiply by 02 mod 0x11B);
  - function gf_mul_const for constants 02, 03, 09, 0B, 0D, 0E;
  - typedef column_t = four bytes;
  - typedef state_t = four column_t;
  - typedef enum mixcol_state_e {IDLE, RUN, DONE}.
- Sub-module aes_mix_one_column (combinational: 32-bit column in, dec, 32-bit column out). Instantiate it COLS_PER_CYCLE times. The column select mux is indexed by step.
- Step counter width is $clog2(N_STEPS) with a minimum of 1.

## Test plan
- Encrypt, COLS_PER_CYCLE=1: input column db 13 53 45 placed in all four columns -> every column 8e 4d a1 bc. out_valid rises exactly 4 cycles after accept.
- Encrypt, mixed columns f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6 | d4 d4 d4 d5 -> 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6 | d5 d5 d7 d6. Run for COLS_PER_CYCLE=1, 2, 4 and check latency 4/2/1.
- Decrypt: 8e 4d a1 bc x4 with in_dec=1 -> db 13 53 45 x4. Also check that a random state round-trips (enc, then dec) to the original.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_state stable, in_ready=0. Then pulse out_ready together with in_valid -> new block accepted the same cycle, next out_valid N_STEPS cycles later.
- Mode per block: issue enc then dec blocks back-to-back, toggling in_dec only during non-accept cycles -> each block uses its own latched mode.
- Reset mid-RUN (step 2 of 4): assert rst_n=0 -> out_valid=0, out_state=0, in_ready=1 asynchronously. After release, a fresh block completes correctly.
